// File: rtl/spike_rate_decoder.sv
// Spike-rate read-out: counts spikes per channel over a fixed window, then
// scans for the most active channel and presents index, count, tie and 7-seg glyph.
module spike_rate_decoder #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 256,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_CH-1:0]  spike_in,
  input  logic             start,
  output logic             busy,
  output logic             result_valid,
  output logic [IDX_W-1:0] winner_idx,
  output logic [CNT_W-1:0] winner_count,
  output logic             tie,
  output logic [6:0]       segments
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  localparam logic [15:0]      LAST_T  = 16'(WINDOW - 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] count_r [N_CH];
  logic [15:0]      timer_r;
  logic [IDX_W-1:0] scan_idx_r, best_idx_r;
  logic [CNT_W-1:0] best_cnt_r;
  logic             best_tie_r;
  logic [CNT_W-1:0] cur_cnt;
  logic [IDX_W-1:0] step_idx;
  logic [CNT_W-1:0] step_cnt;
  logic             step_tie;

  function automatic logic [6:0] seg7(input logic [IDX_W-1:0] idx);
    case (4'(idx))
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    if (ena) begin
      case (state_r)
        IDLE:    state_nxt = start ? COUNT : IDLE;
        COUNT:   state_nxt = (timer_r == LAST_T) ? SCAN : COUNT;
        SCAN:    state_nxt = (scan_idx_r == LAST_CH) ? DONE : SCAN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r <= 16'd0;
      for (int i = 0; i < N_CH; i++) count_r[i] <= {CNT_W{1'b0}};
    end else if (ena) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            timer_r <= 16'd0;
            for (int i = 0; i < N_CH; i++) count_r[i] <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_r;
          end
        end
        COUNT: begin
          timer_r <= timer_r + 16'd1;
          // Saturate rather than wrap so a busy channel can never look quiet.
          for (int i = 0; i < N_CH; i++) begin
            if (spike_in[i] && (count_r[i] != CNT_MAX)) count_r[i] <= count_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: timer_r <= timer_r;
      endcase
    end else begin
      timer_r <= timer_r;
    end
  end

  // One scan step: channel 0 seeds the best; later channels must be strictly greater.
  always_comb begin
    cur_cnt = {CNT_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      cur_cnt = (scan_idx_r == IDX_W'(i)) ? count_r[i] : cur_cnt;
    end
    step_idx = best_idx_r;
    step_cnt = best_cnt_r;
    step_tie = best_tie_r;
    if (scan_idx_r == {IDX_W{1'b0}}) begin
      step_idx = {IDX_W{1'b0}};
      step_cnt = cur_cnt;
      step_tie = 1'b0;
    end else if (cur_cnt > best_cnt_r) begin
      step_idx = scan_idx_r;
      step_cnt = cur_cnt;
      step_tie = 1'b0;
    end else if (cur_cnt == best_cnt_r) begin
      step_tie = 1'b1;
    end else begin
      step_tie = best_tie_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx_r <= {IDX_W{1'b0}};
      best_idx_r <= {IDX_W{1'b0}};
      best_cnt_r <= {CNT_W{1'b0}};
      best_tie_r <= 1'b0;
    end else if (ena) begin
      if (state_r == SCAN) begin
        scan_idx_r <= scan_idx_r + IDX_W'(1);
        best_idx_r <= step_idx;
        best_cnt_r <= step_cnt;
        best_tie_r <= step_tie;
      end else begin
        scan_idx_r <= {IDX_W{1'b0}};
      end
    end else begin
      scan_idx_r <= scan_idx_r;
    end
  end

  // Result outputs load together with the final scan step, i.e. as DONE is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner_idx   <= {IDX_W{1'b0}};
      winner_count <= {CNT_W{1'b0}};
      tie          <= 1'b0;
      segments     <= 7'h00;
    end else if (ena) begin
      busy         <= (state_nxt != IDLE);
      result_valid <= (state_nxt == DONE);
      if ((state_r == SCAN) && (scan_idx_r == LAST_CH)) begin
        winner_idx   <= step_idx;
        winner_count <= step_cnt;
        tie          <= step_tie;
        segments     <= seg7(step_idx);
      end else begin
        winner_idx   <= winner_idx;
      end
    end else begin
      busy <= busy;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised scoreboard bench for spike_rate_decoder: stimulus pushes predicted
// results, an independent monitor pops and compares on every result_valid.
module tb_spike_rate_decoder;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 4;
  localparam int WINDOW = 16;
  localparam int IDX_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic [N_CH-1:0]  spike_in = '0;
  logic             busy, result_valid, tie;
  logic [IDX_W-1:0] winner_idx;
  logic [CNT_W-1:0] winner_count;
  logic [6:0]       segments;

  typedef struct {
    int idx;
    int cnt;
    int tie;
    int seg;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tgt[N_CH];
  int   prob[N_CH];
  int   seg_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .start(start),
    .busy(busy), .result_valid(result_valid), .winner_idx(winner_idx),
    .winner_count(winner_count), .tie(tie), .segments(segments)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_idx"}, winner_idx, 0);
    chk({tag, "_cnt"}, winner_count, 0);
    chk({tag, "_tie"}, tie, 0);
    chk({tag, "_seg"}, segments, 0);
  endtask

  // mode 1: fixed pattern; 2: channel i spikes in its first tgt[i] cycles; else random with prob[i]%.
  task automatic run_window(input int mode, input logic [N_CH-1:0] pat, input int gap_at,
                            input int gap_len, input bit mid_start, input bit rst_in_scan);
    int   raw[N_CH];
    int   k, extra, mx, w, nmax;
    exp_t e;
    extra = 0;
    for (int i = 0; i < N_CH; i++) raw[i] = 0;
    k = cyc + 1;
    ena = 1'b1;
    start = 1'b1;
    spike_in = N_CH'($urandom);
    tick();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      if (t == gap_at) begin
        ena = 1'b0;
        start = 1'b1;
        for (int g = 0; g < gap_len; g++) begin
          spike_in = N_CH'($urandom);
          tick();
        end
        extra += gap_len;
        ena = 1'b1;
        start = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) begin
        case (mode)
          1:       spike_in[i] = pat[i];
          2:       spike_in[i] = (t < tgt[i]);
          default: spike_in[i] = ($urandom_range(0, 99) < prob[i]);
        endcase
        if (spike_in[i]) raw[i]++;
      end
      start = mid_start && (t == 5);
      tick();
      start = 1'b0;
    end
    spike_in = N_CH'($urandom);
    if (rst_in_scan) begin
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_outputs("scan_reset");
      repeat (N_CH + 3) tick();
    end else begin
      mx = 0;
      for (int i = 0; i < N_CH; i++) begin
        if (raw[i] > SAT) raw[i] = SAT;
        if (raw[i] > mx) mx = raw[i];
      end
      w = -1;
      nmax = 0;
      for (int i = 0; i < N_CH; i++) begin
        if (raw[i] == mx) begin
          nmax++;
          if (w < 0) w = i;
        end
      end
      e.idx = w;
      e.cnt = mx;
      e.tie = (nmax > 1) ? 1 : 0;
      e.seg = seg_tab[w];
      e.cyc = k + WINDOW + N_CH + extra;
      sb.push_back(e);
      repeat (N_CH + 1) tick();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ena && result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", result_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_cycle", cyc, mon_e.cyc);
        chk("winner_idx", winner_idx, mon_e.idx);
        chk("winner_count", winner_count, mon_e.cnt);
        chk("tie", tie, mon_e.tie);
        chk("segments", segments, mon_e.seg);
        chk("busy_in_done", busy, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d results pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk_reset_outputs("reset");
    repeat (10) tick();
    chk_reset_outputs("idle");

    run_window(1, 4'b0100, -1, 0, 1'b0, 1'b0);
    run_window(1, 4'b0010, -1, 0, 1'b0, 1'b0);
    tgt = '{0, 5, 0, 5};
    run_window(2, 4'b0000, -1, 0, 1'b0, 1'b0);
    tgt = '{0, 5, 0, 6};
    run_window(2, 4'b0000, -1, 0, 1'b0, 1'b0);
    tgt = '{3, 0, 12, 9};
    run_window(2, 4'b0000, -1, 0, 1'b0, 1'b0);
    prob = '{40, 60, 30, 50};
    run_window(3, 4'b0000, -1, 0, 1'b1, 1'b0);
    run_window(3, 4'b0000, 6, 7, 1'b0, 1'b0);
    run_window(3, 4'b0000, -1, 0, 1'b0, 1'b1);
    run_window(1, 4'b0000, -1, 0, 1'b0, 1'b0);
    run_window(3, 4'b0000, -1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < N_CH; i++) prob[i] = $urandom_range(0, 90);
      repeat ($urandom_range(0, 2)) tick();
      run_window(3, 4'b0000, ($urandom_range(0, 3) == 0) ? $urandom_range(0, WINDOW - 1) : -1,
                 $urandom_range(1, 5), 1'(($urandom_range(0, 4) == 0)), 1'b0);
    end

    repeat (10) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
